i2c_shift_engine: RTL and testbench
===================================

# i2c_shift_engine

Parametrised serial/parallel shift engine for the I2C controller datapath: loads a parallel word, serialises it one bit per `shift` strobe while simultaneously deserialising the incoming line bit into the vacated position, and signals completion after exactly WIDTH shifts. It replaces the plain load/shift register: bit counting, a completion pulse, abort, and selectable bit order now live inside the block, so the byte-level FSM only issues `load` and SCL-aligned `shift` strobes.

## Interface
- `WIDTH`, 8, word width in bits; legal range 2..32
- `MSB_FIRST`, 1, 1 = transmit/receive MSB first (I2C order), 0 = LSB first
- `clock`  in  1  single system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `load`  in  1  capture `ins`, start a transfer
- `abort`  in  1  drop the current transfer, return to IDLE, no `done`
- `shift`  in  1  one-cycle strobe: advance one bit
- `sin`  in  1  serial input bit (sampled SDA)
- `ins`  in  WIDTH  parallel load data
- `out`  out  WIDTH  register contents; holds the received word after `done`
- `sout`  out  1  current serial output bit
- `count`  out  CW  bits shifted so far, CW = $clog2(WIDTH+1)
- `busy`  out  1  high in SHIFT state
- `done`  out  1  one-cycle completion pulse

## Operation
- Reset (synchronous, `reset`=1 at the edge): `out`=0, `count`=0, state IDLE, `busy`=0, `done`=0, `sout`=0. Reset overrides every other input.
- States: IDLE, SHIFT, DONE.
- IDLE: `load` → `out`<=`ins`, `count`<=0, go to SHIFT. `shift` ignored.
- SHIFT: `shift` → MSB_FIRST=1: `out`<={out[WIDTH-2:0], sin}; MSB_FIRST=0: `out`<={sin, out[WIDTH-1:1]}; `count`<=`count`+1. When this shift makes `count`=WIDTH, go to DONE.
- DONE: lasts exactly one cycle, then IDLE. `load` in DONE starts a new transfer (goes to SHIFT, no IDLE cycle); `shift` ignored.
- `sout` = `out[WIDTH-1]` (MSB_FIRST=1) or `out[0]` (MSB_FIRST=0), purely combinational from the register.
- Priority, highest first: `reset`, `abort`, `load`, `shift`.
- `abort` in any state: go to IDLE, `count`<=0, `out` unchanged, no `done`.
- `load` during SHIFT: restart: reload `ins`, `count`<=0, stay in SHIFT; a coincident `shift` is dropped.
- `count` never exceeds WIDTH; it holds WIDTH in DONE and IDLE until the next `load`/`abort`/reset.

## Timing
- `busy`, `done` are registered state decodes: `busy`=1 from the cycle after `load`; `done`=1 for the single cycle after the final `shift` edge; `busy` is 0 in that same cycle.
- Minimum transfer: `load` + WIDTH back-to-back `shift` cycles → `done` at cycle WIDTH+1 after `load`.
- `shift` may be non-contiguous; any gap length is legal and state holds in between.
- New `sout` is valid the cycle after each `shift` edge. `sin` is sampled on the `shift` edge.

## Structure
- Shared package `i2c_pkg`: state enum (IDLE, SHIFT, DONE) and a CW width helper; the byte FSM reuses both.
- One sub-module: `bit_counter` (parameter MAX; clear, inc, count, at_max), instantiated with MAX=WIDTH. Shift datapath and FSM stay in the top module.

## Test plan
- Reset: drive garbage on all inputs with `reset`=1 → `out`=0, `count`=0, `busy`=0, `done`=0, `sout`=0.
- TX/RX, WIDTH=8, MSB_FIRST=1: load 0xA5, 8 back-to-back shifts with `sin` sequence 0,0,1,1,1,1,0,0 → `sout` sequence 1,0,1,0,0,1,0,1; `done` one cycle after 8th shift; `out`=0x3C.
- LSB_FIRST, WIDTH=8: load 0x01, `sin`=1 throughout, 8 shifts with random gaps → `sout` first bit 1 then 0s; `out`=0xFF; `done` exactly once.
- Abort at `count`=3 → IDLE, no `done`, `out` keeps partially shifted value; subsequent shifts ignored.
- Load with coincident shift during SHIFT at `count`=5 → `out`=new `ins`, `count`=0; load in DONE cycle → back-to-back transfer with no IDLE gap.
- WIDTH=2 and WIDTH=32 instances: full transfer → `done` after exactly WIDTH shifts, `count` saturates at WIDTH.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and counter-width helper for the I2C datapath
package i2c_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic int cw(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/i2c_shift_engine_bit_counter.sv
// bit_counter: saturating up-counter from 0 to MAX with synchronous clear
module bit_counter import i2c_pkg::*; #(
  parameter int MAX = 8,
  localparam int CW = cw(MAX)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          at_max
);
  assign at_max = count == CW'(MAX);
  // clear wins over inc; stop counting once MAX is reached
  always_ff @(posedge clock)
    if (reset || clear) count <= '0;
    else if (inc && !at_max) count <= count + 1'b1;
endmodule

// File: rtl/i2c_shift_engine.sv
// i2c_shift_engine: load/serialise/deserialise shift register with bit count and done pulse
module i2c_shift_engine import i2c_pkg::*; #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW = cw(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             abort,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] ins,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done
);
  state_t state, nxt;
  logic sh, at_max, last;
  logic [WIDTH-1:0] shifted;
  assign sh      = state == SHIFT && shift && !abort && !load && !at_max;
  assign last    = count == CW'(WIDTH - 1);
  assign shifted = MSB_FIRST ? {out[WIDTH-2:0], sin} : {sin, out[WIDTH-1:1]};
  assign sout    = MSB_FIRST ? out[WIDTH-1] : out[0];
  bit_counter #(.MAX(WIDTH)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clear (abort || load),
    .inc   (sh),
    .count (count),
    .at_max(at_max)
  );
  // abort beats load; SHIFT leaves only on the final shift, DONE always falls back to IDLE
  always_comb
    nxt = abort ? IDLE : load ? SHIFT : (state == SHIFT) ? ((sh && last) ? DONE : SHIFT) : IDLE;
  // state plus registered busy/done decodes of the next state
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      busy  <= nxt == SHIFT;
      done  <= nxt == DONE;
    end
  // data register: abort freezes it, load captures, shift moves one bit
  always_ff @(posedge clock)
    if (reset) out <= '0;
    else if (!abort && load) out <= ins;
    else if (sh) out <= shifted;
endmodule

// File: tb/tb_i2c_shift_engine.sv
// tb_i2c_shift_engine: scoreboard bench for MSB/LSB-first, abort, restart and width extremes
module tb_i2c_shift_engine;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic load_a, abort_a, shift_a, sin_a, sout_a, busy_a, done_a;
  logic [7:0] ins_a, out_a;
  logic [3:0] count_a;
  logic load_b, abort_b, shift_b, sin_b, sout_b, busy_b, done_b;
  logic [7:0] ins_b, out_b;
  logic [3:0] count_b;
  logic load_c, abort_c, shift_c, sin_c, sout_c, busy_c, done_c;
  logic [1:0] ins_c, out_c;
  logic [1:0] count_c;
  logic load_d, abort_d, shift_d, sin_d, sout_d, busy_d, done_d;
  logic [31:0] ins_d, out_d;
  logic [5:0] count_d;

  i2c_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (.clock(clock), .reset(reset), .load(load_a), .abort(abort_a),
    .shift(shift_a), .sin(sin_a), .ins(ins_a), .out(out_a), .sout(sout_a), .count(count_a), .busy(busy_a), .done(done_a));
  i2c_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (.clock(clock), .reset(reset), .load(load_b), .abort(abort_b),
    .shift(shift_b), .sin(sin_b), .ins(ins_b), .out(out_b), .sout(sout_b), .count(count_b), .busy(busy_b), .done(done_b));
  i2c_shift_engine #(.WIDTH(2), .MSB_FIRST(1'b1)) u_c (.clock(clock), .reset(reset), .load(load_c), .abort(abort_c),
    .shift(shift_c), .sin(sin_c), .ins(ins_c), .out(out_c), .sout(sout_c), .count(count_c), .busy(busy_c), .done(done_c));
  i2c_shift_engine #(.WIDTH(32), .MSB_FIRST(1'b1)) u_d (.clock(clock), .reset(reset), .load(load_d), .abort(abort_d),
    .shift(shift_d), .sin(sin_d), .ins(ins_d), .out(out_d), .sout(sout_d), .count(count_d), .busy(busy_d), .done(done_d));

  int n_cmp = 0;
  int n_bad = 0;
  int nd_a = 0, nd_b = 0, nd_c = 0, nd_d = 0;
  logic [31:0] qa[$], qb[$], qc[$], qd[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboard: every done pulse must match the oldest pending expected word
  always @(negedge clock)
    if (!reset && done_a) begin
      nd_a++;
      check("done_a_pending", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) check("done_a_out", 32'(out_a), qa.pop_front());
    end
  always @(negedge clock)
    if (!reset && done_b) begin
      nd_b++;
      check("done_b_pending", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) check("done_b_out", 32'(out_b), qb.pop_front());
    end
  always @(negedge clock)
    if (!reset && done_c) begin
      nd_c++;
      check("done_c_pending", 32'(qc.size() != 0), 32'd1);
      if (qc.size() != 0) check("done_c_out", 32'(out_c), qc.pop_front());
    end
  always @(negedge clock)
    if (!reset && done_d) begin
      nd_d++;
      check("done_d_pending", 32'(qd.size() != 0), 32'd1);
      if (qd.size() != 0) check("done_d_out", out_d, qd.pop_front());
    end

  initial begin
    logic [7:0] txv, rxv;
    logic [31:0] bits;
    reset = 1'b1;
    {load_a, abort_a, shift_a, sin_a, ins_a} = {4'b1011, 8'hFF};
    {load_b, abort_b, shift_b, sin_b, ins_b} = {4'b1111, 8'hA5};
    {load_c, abort_c, shift_c, sin_c, ins_c} = {4'b1010, 2'b11};
    {load_d, abort_d, shift_d, sin_d, ins_d} = {4'b1011, 32'hDEADBEEF};
    tick();
    tick();
    check("rst_out", 32'(out_a), 32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_sout", 32'(sout_a), 32'd0);
    check("rst_out_b", 32'(out_b), 32'd0);
    check("rst_out_d", out_d, 32'd0);
    {load_a, abort_a, shift_a, sin_a, ins_a} = '0;
    {load_b, abort_b, shift_b, sin_b, ins_b} = '0;
    {load_c, abort_c, shift_c, sin_c, ins_c} = '0;
    {load_d, abort_d, shift_d, sin_d, ins_d} = '0;
    reset = 1'b0;
    tick();

    txv = 8'hA5;
    rxv = 8'h3C;
    ins_a = txv;
    load_a = 1'b1;
    qa.push_back(32'h3C);
    tick();
    load_a = 1'b0;
    check("msb_busy_after_load", 32'(busy_a), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("msb_sout", 32'(sout_a), 32'(txv[7-i]));
      shift_a = 1'b1;
      sin_a = rxv[7-i];
      tick();
      check("msb_done_timing", 32'(done_a), 32'(i == 7));
    end
    shift_a = 1'b0;
    check("msb_busy_in_done", 32'(busy_a), 32'd0);
    check("msb_count_full", 32'(count_a), 32'd8);
    tick();
    check("msb_done_one_cycle", 32'(done_a), 32'd0);
    shift_a = 1'b1;
    tick();
    tick();
    shift_a = 1'b0;
    check("idle_shift_ignored", 32'(out_a), 32'h3C);
    check("idle_count_holds", 32'(count_a), 32'd8);

    ins_a = 8'h5A;
    load_a = 1'b1;
    tick();
    load_a = 1'b0;
    sin_a = 1'b1;
    shift_a = 1'b1;
    repeat (3) tick();
    shift_a = 1'b0;
    check("abort_pre_count", 32'(count_a), 32'd3);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("abort_count", 32'(count_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_out_kept", 32'(out_a), 32'hD7);
    shift_a = 1'b1;
    repeat (4) tick();
    shift_a = 1'b0;
    check("abort_shift_ignored", 32'(out_a), 32'hD7);

    ins_a = 8'h5A;
    load_a = 1'b1;
    tick();
    load_a = 1'b0;
    sin_a = 1'b0;
    shift_a = 1'b1;
    repeat (5) tick();
    check("restart_pre_count", 32'(count_a), 32'd5);
    check("restart_pre_out", 32'(out_a), 32'h40);
    ins_a = 8'hC3;
    load_a = 1'b1;
    sin_a = 1'b1;
    qa.push_back(32'hAA);
    tick();
    load_a = 1'b0;
    check("restart_out", 32'(out_a), 32'hC3);
    check("restart_count", 32'(count_a), 32'd0);
    check("restart_busy", 32'(busy_a), 32'd1);
    rxv = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      sin_a = rxv[7-i];
      tick();
    end
    shift_a = 1'b0;
    check("restart_done", 32'(done_a), 32'd1);
    ins_a = 8'h0F;
    load_a = 1'b1;
    qa.push_back(32'h00);
    tick();
    load_a = 1'b0;
    check("b2b_busy", 32'(busy_a), 32'd1);
    check("b2b_done_low", 32'(done_a), 32'd0);
    check("b2b_out", 32'(out_a), 32'h0F);
    check("b2b_count", 32'(count_a), 32'd0);
    sin_a = 1'b0;
    shift_a = 1'b1;
    repeat (8) tick();
    shift_a = 1'b0;
    tick();
    check("a_done_pulses", 32'(nd_a), 32'd3);

    ins_b = 8'h01;
    load_b = 1'b1;
    qb.push_back(32'hFF);
    tick();
    load_b = 1'b0;
    sin_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      check("lsb_sout", 32'(sout_b), 32'(i == 0));
      shift_b = 1'b1;
      tick();
      shift_b = 1'b0;
    end
    tick();
    check("lsb_out", 32'(out_b), 32'hFF);
    check("lsb_sout_last", 32'(sout_b), 32'd1);
    check("lsb_done_once", 32'(nd_b), 32'd1);

    bits = $urandom;
    ins_c = 2'b01;
    load_c = 1'b1;
    qc.push_back(32'(bits[1:0]));
    tick();
    load_c = 1'b0;
    shift_c = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sin_c = bits[1-i];
      tick();
      check("w2_done_timing", 32'(done_c), 32'(i == 1));
    end
    tick();
    tick();
    shift_c = 1'b0;
    check("w2_count_sat", 32'(count_c), 32'd2);
    check("w2_out", 32'(out_c), 32'(bits[1:0]));
    check("w2_done_once", 32'(nd_c), 32'd1);

    bits = $urandom;
    ins_d = ~bits;
    load_d = 1'b1;
    qd.push_back(bits);
    tick();
    load_d = 1'b0;
    shift_d = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sin_d = bits[31-i];
      tick();
      if (i >= 30) check("w32_done_timing", 32'(done_d), 32'(i == 31));
    end
    tick();
    tick();
    shift_d = 1'b0;
    check("w32_count_sat", 32'(count_d), 32'd32);
    check("w32_out", out_d, bits);
    check("w32_done_once", 32'(nd_d), 32'd1);

    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
